// File: rtl/event_rx.sv
// Receiver for the row/column event arbiter: validates grant/event agreement and
// buffers decoded events in a FWFT FIFO. Define EVT_TIMESTAMP_EN to timestamp entries.
module event_rx #(
  parameter int ROWS     = 8,
  parameter int COLS     = 8,
  parameter int POLARITY = 2,
  parameter int ROW_W    = $clog2(ROWS),
  parameter int COL_W    = $clog2(COLS),
  parameter int WIDTH    = ROW_W + COL_W + POLARITY,
  parameter int DEPTH    = 8,
  parameter int TS_W     = 16
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [ROWS-1:0][COLS-1:0]     gnt_i,
  input  logic [WIDTH-1:0]              data_i,
  input  logic                          evt_ready_i,
  output logic                          evt_valid_o,
  output logic [ROW_W-1:0]              evt_row_o,
  output logic [COL_W-1:0]              evt_col_o,
  output logic [POLARITY-1:0]           evt_pol_o,
  output logic [TS_W-1:0]               evt_ts_o,
  output logic [$clog2(DEPTH):0]        fifo_count_o,
  output logic                          overflow_o,
  output logic                          err_o,
  output logic [7:0]                    drop_cnt_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int CELLS = ROWS * COLS;
`ifdef EVT_TIMESTAMP_EN
  localparam int ENTRY_W = WIDTH + TS_W;
`else
  localparam int ENTRY_W = WIDTH;
`endif

  logic [ROW_W-1:0]    in_row;
  logic [COL_W-1:0]    in_col;
  logic [POLARITY-1:0] in_pol;
  logic [CELLS-1:0]    gnt_flat;
  logic [CELLS-1:0]    gnt_expect;
  logic                evt_present;
  logic                pol_ok;
  logic                well_formed;

  logic [ENTRY_W-1:0]  mem [DEPTH];
  logic [ENTRY_W-1:0]  wdata;
  logic [ENTRY_W-1:0]  head_q;
  logic [ENTRY_W-1:0]  head_next;
  logic [PTR_W-1:0]    wr_ptr_q;
  logic [PTR_W-1:0]    rd_ptr_q;
  logic [PTR_W-1:0]    rd_ptr_next;
  logic [CNT_W-1:0]    count_q;
  logic [CNT_W-1:0]    count_next;
  logic                full;
  logic                push;
  logic                pop;
  logic                overflow_q;
  logic                err_q;
  logic [7:0]          drop_q;

  assign in_row   = data_i[WIDTH-1 -: ROW_W];
  assign in_col   = data_i[WIDTH-1-ROW_W -: COL_W];
  assign in_pol   = data_i[POLARITY-1:0];
  assign gnt_flat = gnt_i;

  // The grant must be exactly the single bit addressed by the event word;
  // this one comparison covers both one-hotness and position agreement.
  always_comb begin
    gnt_expect = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        gnt_expect[r*COLS + c] = (int'(in_row) == r) && (int'(in_col) == c);
      end
    end
  end

  assign evt_present = |gnt_flat;
  assign pol_ok      = (in_pol == POLARITY'(2'b10)) || (in_pol == POLARITY'(2'b01));
  assign well_formed = (gnt_flat == gnt_expect) && pol_ok;

  assign full        = (count_q == CNT_W'(DEPTH));
  assign pop         = evt_valid_o && evt_ready_i;
  assign push        = evt_present && well_formed && (!full || pop);
  assign rd_ptr_next = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
  assign count_next  = count_q + CNT_W'(push) - CNT_W'(pop);

`ifdef EVT_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_q + TS_W'(1);
    end
  end

  assign wdata    = {in_row, in_col, in_pol, ts_q};
  assign evt_ts_o = head_q[TS_W-1:0];
`else
  assign wdata    = {in_row, in_col, in_pol};
  assign evt_ts_o = '0;
`endif

  // Storage carries no reset; emptiness is tracked solely by the pointers and count.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr_q] <= wdata;
    end
  end

  // Head register: takes the entry being written when it lands in the next head slot.
  always_comb begin
    head_next = mem[rd_ptr_next];
    if (push && (wr_ptr_q == rd_ptr_next)) begin
      head_next = wdata;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      rd_ptr_q <= rd_ptr_next;
      count_q  <= count_next;
      if (count_next != '0) begin
        head_q <= head_next;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      overflow_q <= 1'b0;
      err_q      <= 1'b0;
      drop_q     <= '0;
    end else begin
      if (evt_present && !well_formed) begin
        err_q <= 1'b1;
      end
      if (evt_present && well_formed && !push) begin
        overflow_q <= 1'b1;
      end
      if (evt_present && !push && (drop_q != 8'hFF)) begin
        drop_q <= drop_q + 8'd1;
      end
    end
  end

  assign evt_valid_o  = (count_q != '0);
  assign evt_row_o    = head_q[ENTRY_W-1 -: ROW_W];
  assign evt_col_o    = head_q[ENTRY_W-1-ROW_W -: COL_W];
  assign evt_pol_o    = head_q[ENTRY_W-1-ROW_W-COL_W -: POLARITY];
  assign fifo_count_o = count_q;
  assign overflow_o   = overflow_q;
  assign err_o        = err_q;
  assign drop_cnt_o   = drop_q;

endmodule

// File: tb/tb_event_rx.sv
// Scoreboard bench for event_rx: a queue-level reference model predicts each event's
// fate; a negedge monitor compares the FIFO head and status outputs against it.
module tb_event_rx;

  localparam int ROWS     = 8;
  localparam int COLS     = 8;
  localparam int POLARITY = 2;
  localparam int ROW_W    = 3;
  localparam int COL_W    = 3;
  localparam int WIDTH    = ROW_W + COL_W + POLARITY;
  localparam int DEPTH    = 8;
  localparam int TS_W     = 4;
  localparam int TS_MOD   = 1 << TS_W;
`ifdef EVT_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif

  logic                      clk_i = 1'b0;
  logic                      reset_i = 1'b1;
  logic [ROWS-1:0][COLS-1:0] gnt_i = '0;
  logic [WIDTH-1:0]          data_i = '0;
  logic                      evt_ready_i = 1'b0;
  logic                      evt_valid_o;
  logic [ROW_W-1:0]          evt_row_o;
  logic [COL_W-1:0]          evt_col_o;
  logic [POLARITY-1:0]       evt_pol_o;
  logic [TS_W-1:0]           evt_ts_o;
  logic [$clog2(DEPTH):0]    fifo_count_o;
  logic                      overflow_o;
  logic                      err_o;
  logic [7:0]                drop_cnt_o;

  event_rx #(
    .ROWS(ROWS), .COLS(COLS), .POLARITY(POLARITY), .ROW_W(ROW_W), .COL_W(COL_W),
    .WIDTH(WIDTH), .DEPTH(DEPTH), .TS_W(TS_W)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .gnt_i(gnt_i), .data_i(data_i),
    .evt_ready_i(evt_ready_i), .evt_valid_o(evt_valid_o), .evt_row_o(evt_row_o),
    .evt_col_o(evt_col_o), .evt_pol_o(evt_pol_o), .evt_ts_o(evt_ts_o),
    .fifo_count_o(fifo_count_o), .overflow_o(overflow_o), .err_o(err_o),
    .drop_cnt_o(drop_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {int row; int col; int pol; int ts;} evt_t;

  int   checks = 0;
  int   errors = 0;
  evt_t model_q[$];
  evt_t exp_q[$];
  evt_t m_last = '{default: 0};
  int   m_ts = 0;
  int   m_overflow = 0;
  int   m_err = 0;
  int   m_drop = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Reference model: decides each sampled event's fate from the rules alone.
  always @(posedge clk_i) begin : model
    int   ones;
    int   gr;
    int   gc;
    bit   well;
    evt_t e;
    if (reset_i) begin
      model_q.delete();
      m_ts = 0; m_overflow = 0; m_err = 0; m_drop = 0;
      m_last = '{default: 0};
    end else begin
      if (model_q.size() != 0 && evt_ready_i) m_last = model_q.pop_front();
      ones = $countones(gnt_i);
      if (ones != 0) begin
        gr = -1; gc = -1;
        for (int r = 0; r < ROWS; r++)
          for (int c = 0; c < COLS; c++)
            if (gnt_i[r][c]) begin gr = r; gc = c; end
        e.row = int'(data_i[WIDTH-1 -: ROW_W]);
        e.col = int'(data_i[WIDTH-1-ROW_W -: COL_W]);
        e.pol = int'(data_i[POLARITY-1:0]);
        e.ts  = TS_EN ? (m_ts % TS_MOD) : 0;
        well = (ones == 1) && (gr == e.row) && (gc == e.col) && (e.pol == 1 || e.pol == 2);
        if (!well) begin
          m_err = 1;
          m_drop = (m_drop < 255) ? m_drop + 1 : 255;
        end else if (model_q.size() < DEPTH) begin
          model_q.push_back(e);
          exp_q.push_back(e);
        end else begin
          m_overflow = 1;
          m_drop = (m_drop < 255) ? m_drop + 1 : 255;
        end
      end
      m_ts++;
    end
  end

  // Monitor: away from the active edge, compare what the DUT presents.
  always @(negedge clk_i) begin
    if (reset_i) begin
      exp_q.delete();
    end else begin
      checkOutput("valid", int'(evt_valid_o), int'(model_q.size() != 0));
      checkOutput("count", int'(fifo_count_o), model_q.size());
      checkOutput("overflow", int'(overflow_o), m_overflow);
      checkOutput("err", int'(err_o), m_err);
      checkOutput("drop_cnt", int'(drop_cnt_o), m_drop);
      if (exp_q.size() != 0) begin
        checkOutput("head_row", int'(evt_row_o), exp_q[0].row);
        checkOutput("head_col", int'(evt_col_o), exp_q[0].col);
        checkOutput("head_pol", int'(evt_pol_o), exp_q[0].pol);
        checkOutput("head_ts", int'(evt_ts_o), exp_q[0].ts);
        if (evt_valid_o && evt_ready_i) void'(exp_q.pop_front());
      end else begin
        checkOutput("hold_row", int'(evt_row_o), m_last.row);
        checkOutput("hold_col", int'(evt_col_o), m_last.col);
        checkOutput("hold_pol", int'(evt_pol_o), m_last.pol);
        checkOutput("hold_ts", int'(evt_ts_o), m_last.ts);
      end
    end
  end

  task automatic applyStimulus(input logic [ROWS-1:0][COLS-1:0] g, input logic [WIDTH-1:0] d,
                               input logic rdy);
    gnt_i = g;
    data_i = d;
    evt_ready_i = rdy;
    @(posedge clk_i);
    #1;
  endtask

  task automatic sendRaw(input int gr, input int gc, input int dr, input int dc, input int pol,
                         input bit second_bit, input logic rdy);
    logic [ROWS-1:0][COLS-1:0] g;
    g = '0;
    g[gr][gc] = 1'b1;
    if (second_bit) g[(gr + 1) % ROWS][gc] = 1'b1;
    applyStimulus(g, {ROW_W'(dr), COL_W'(dc), POLARITY'(pol)}, rdy);
  endtask

  task automatic sendEvent(input int r, input int c, input int pol, input logic rdy);
    sendRaw(r, c, r, c, pol, 1'b0, rdy);
  endtask

  task automatic idle(input logic rdy, input int n);
    for (int i = 0; i < n; i++) applyStimulus('0, '0, rdy);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_valid"}, int'(evt_valid_o), 0);
    checkOutput({tag, "_count"}, int'(fifo_count_o), 0);
    checkOutput({tag, "_overflow"}, int'(overflow_o), 0);
    checkOutput({tag, "_err"}, int'(err_o), 0);
    checkOutput({tag, "_drop"}, int'(drop_cnt_o), 0);
    checkOutput({tag, "_row"}, int'(evt_row_o), 0);
    checkOutput({tag, "_ts"}, int'(evt_ts_o), 0);
  endtask

  initial begin
    #4;
    checkResetState("por");
    repeat (3) @(posedge clk_i);
    #1;
    reset_i = 1'b0;

    // Single event, consumer ready.
    sendEvent(7, 0, 1, 1'b1);
    idle(1'b1, 3);

    // Burst of 10 with backpressure, then drain.
    for (int i = 0; i < 10; i++) sendEvent(i % ROWS, (3 * i) % COLS, 1 + (i % 2), 1'b0);
    idle(1'b0, 3);
    idle(1'b1, DEPTH + 2);

    // Full FIFO with a simultaneous push and pop.
    for (int i = 0; i < DEPTH; i++) sendEvent(i, 7 - i, 2, 1'b0);
    sendEvent(4, 4, 1, 1'b1);
    idle(1'b0, 2);
    idle(1'b1, DEPTH + 2);

    // Malformed: position mismatch, bad polarity, two grant bits.
    sendRaw(1, 5, 1, 4, 1, 1'b0, 1'b1);
    sendRaw(2, 3, 2, 3, 3, 1'b0, 1'b1);
    sendRaw(5, 6, 5, 6, 2, 1'b1, 1'b1);
    sendRaw(6, 1, 6, 1, 0, 1'b0, 1'b1);
    idle(1'b1, 2);

    // Timestamp wrap: capture at the all-ones value and the next one.
    for (int i = 0; i < TS_MOD && (m_ts % TS_MOD) != TS_MOD - 1; i++) idle(1'b1, 1);
    sendEvent(3, 3, 2, 1'b0);
    sendEvent(4, 2, 1, 1'b0);
    idle(1'b1, 3);

    // Randomized mix of good, malformed and idle cycles with random backpressure.
    for (int i = 0; i < 500; i++) begin
      int   k;
      int   r;
      int   c;
      logic rdy;
      k   = $urandom_range(99);
      r   = $urandom_range(ROWS - 1);
      c   = $urandom_range(COLS - 1);
      rdy = ($urandom_range(99) < 45);
      if (k < 55)      sendEvent(r, c, 1 + $urandom_range(1), rdy);
      else if (k < 61) sendRaw(r, c, r, (c + 1 + $urandom_range(COLS - 2)) % COLS, 1, 1'b0, rdy);
      else if (k < 66) sendRaw(r, c, r, c, ($urandom_range(1) != 0) ? 3 : 0, 1'b0, rdy);
      else if (k < 70) sendRaw(r, c, r, c, 2, 1'b1, rdy);
      else             idle(rdy, 1);
    end
    idle(1'b1, DEPTH + 2);

    // Long stall to push the drop counter into saturation.
    for (int i = 0; i < 300; i++) sendEvent(i % ROWS, i % COLS, 2, 1'b0);
    idle(1'b1, DEPTH + 2);

    // Reset mid-stream with events queued; an event is held on the bus through reset.
    for (int i = 0; i < 5; i++) sendEvent(i, i, 1, 1'b0);
    gnt_i = '0;
    gnt_i[6][2] = 1'b1;
    data_i = {ROW_W'(6), COL_W'(2), POLARITY'(2)};
    #2;
    reset_i = 1'b1;
    #1;
    checkResetState("midrst");
    repeat (2) @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    idle(1'b1, 4);

    checkOutput("drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
